pcm_to_pdm: RTL and testbench
=============================

# pcm_to_pdm

Second-order sigma-delta modulator that converts the 44 kHz signed 16-bit PCM stream (mixer, filterbank or pass-through output) into a 1-bit PDM stream at the fast mic clock rate (4.4 MHz, OSR = 100). It is the transmit-side counterpart of the PDM-to-PCM CIC decimator. Its uses are:
- driving SPKL/SPKR through an analog lowpass as an alternative to the PWM path;
- closing a PDM loopback (pcm_to_pdm -> pdm_to_pcm) for self-test.

It includes a 2-entry input FIFO so producers with jittery valid timing (filterbank FSM, mixer FSM) are decoupled from the fixed output sample grid.

## Interface
Parameters:
- OSR, 100: clk cycles (PDM bits) per PCM sample; must be ≥ 2; matches the decimator's DECIMATE.
- I1_W, 20: integrator 1 width (signed).
- I2_W, 24: integrator 2 width (signed).

Ports:
- clk  in  1  fast clock (MIC_CLK domain, 4.4 MHz); one PDM bit per cycle.
- rst  in  1  asynchronous, active-high reset.
- pcm_in  in  16  signed PCM sample.
- pcm_valid  in  1  sample strobe; a transfer occurs when pcm_valid && pcm_ready.
- pcm_ready  out  1  combinational, = (fifo_count < 2).
- pdm_out  out  1  registered PDM bit.
- sample_strobe  out  1  one-cycle pulse when a new sample becomes the active modulator input.
- underrun  out  1  one-cycle pulse when a sample load finds the FIFO empty.

## Operation
FIFO:
- Depth 2 with a fifo_count register (0..2).
- Push on pcm_valid && pcm_ready.
- Pop on the load event (defined below) if fifo_count > 0.
- Simultaneous push and pop: both take effect, fifo_count unchanged, order preserved.
- No bypass: a sample pushed in the load cycle is not visible to that load.

Phase counter:
- ph is $clog2(OSR) bits wide and counts 0..OSR-1, wrapping to 0.
- Load event is ph == OSR-1.
- On a load with fifo_count > 0: x <= FIFO head, then sample_strobe = 1 next cycle.
- On a load with fifo_count == 0: x holds its previous value, then underrun = 1 next cycle.

Modulator (updated every cycle):
- xs = x >>> 1 (half-scale input for stability).
- f = pdm_out ? +32768 : −32768.
- i1' = sat_I1(i1 + xs − f).
- i2' = sat_I2(i2 + i1' − f).
- pdm_out' = (i2' ≥ 0).
- sat_N clamps to [−2^(N−1), 2^(N−1)−1]. All arithmetic is signed, with sign extension before adds.
- Ones density converges to (1 + xs/32768)/2.

## Timing
Reset:
- Asynchronous: all state clears immediately on rst assertion, including mid-sample and mid-handshake.
- Reset values:
  - pdm_out = 0, sample_strobe = 0, underrun = 0.
  - pcm_ready = 1 (fifo empty), fifo_count = 0.
  - ph = 0, x = 0, i1 = 0, i2 = 0.
- Samples offered during reset are dropped.
- ph = 0 on the first clk edge after deassertion, so the first load occurs OSR−1 edges later.

Latency:
- A sample pushed at edge t with FIFO empty is loaded at the next edge where ph == OSR-1 (the load must be strictly after t).
- sample_strobe is asserted in the cycle following the load edge.
- The first PDM bit influenced by the new x appears on pdm_out one edge after the load.

Steady state:
- A producer at exactly one push per OSR cycles never sees pcm_ready low and never underruns once 1 sample is banked.
- pcm_ready drops only when 2 samples are banked.
- sample_strobe and underrun are mutually exclusive; exactly one of them pulses per OSR cycles.

Wrap and saturation:
- ph wraps with no idle cycle.
- Integrators never wrap; they clamp at their saturation limits.

## Test plan
- Reset: assert rst mid-run with pdm_out = 1 and fifo_count = 2 -> every output is at its reset value in the same cycle, without waiting for an edge. After release, the first sample_strobe/underrun occurs exactly OSR cycles after the first edge.
- DC zero: push 0x0000 every 100 cycles for 50 samples -> ones count over the last 4000 bits is 2000 ± 4; underrun never pulses.
- DC +16384: push 16384 every 100 cycles -> ones density over 4000 bits is 2500 ± 5 (62.5%). With −16384 the count is 1500 ± 5.
- Backpressure and ordering:
  - Push 3 samples on consecutive cycles -> pcm_ready is 0 after the 2nd push and the 3rd is not accepted.
  - The accepted samples load in order on two successive loads.
  - Push coincident with a load while full -> pcm_ready stays 0 in that cycle, since readiness is computed before the pop.
- Underrun: stop pushing -> underrun pulses once per 100 cycles, x holds its last value, and density is unchanged. A push landing in the load cycle while empty -> underrun pulses, and the sample loads one period later.
- Full-scale stress and loopback:
  - Input +32767 / −32768 for 200 samples -> i1 and i2 never exceed their saturation bounds, and density is ≥ 74.5% / ≤ 25.5%.
  - A 1 kHz sine of amplitude 16000 fed through pdm_to_pcm (DECIMATE = 100) -> the recovered sine frequency matches and its amplitude is within 1 dB of the expected half-scale gain.

Source files
------------

// File: rtl/pcm_to_pdm.sv
// pcm_to_pdm: second-order sigma-delta modulator turning 16-bit PCM into a 1-bit PDM stream,
// with a 2-deep input FIFO decoupling the producer from the OSR-cycle load grid.
module pcm_to_pdm #(
   parameter int OSR  = 100,
   parameter int I1_W = 20,
   parameter int I2_W = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] pcm_in,
   input  logic               pcm_valid,
   output logic               pcm_ready,
   output logic               pdm_out,
   output logic               sample_strobe,
   output logic               underrun
);
   localparam int PW = $clog2(OSR);
   localparam int SW = I2_W + 2;
   localparam logic signed [SW-1:0] I1_MAX = {{(SW-I1_W+1){1'b0}}, {(I1_W-1){1'b1}}};
   localparam logic signed [SW-1:0] I1_MIN = ~I1_MAX;
   localparam logic signed [SW-1:0] I2_MAX = {{(SW-I2_W+1){1'b0}}, {(I2_W-1){1'b1}}};
   localparam logic signed [SW-1:0] I2_MIN = ~I2_MAX;

   logic [PW-1:0]          ph_q, ph_d;
   logic [1:0]             cnt_q, cnt_d;
   logic signed [15:0]     head_q, head_d, tail_q, tail_d, x_q, x_d;
   logic signed [I1_W-1:0] i1_q, i1_d;
   logic signed [I2_W-1:0] i2_q, i2_d;
   logic                   pdm_q, pdm_d, strobe_q, strobe_d, under_q, under_d;
   logic                   load, push, pop;
   logic signed [SW-1:0]   f, s1, s2;

   assign pcm_ready     = cnt_q < 2'd2;
   assign pdm_out       = pdm_q;
   assign sample_strobe = strobe_q;
   assign underrun      = under_q;

   always_comb begin
      load     = ph_q == PW'(OSR - 1);
      push     = pcm_valid && pcm_ready;
      pop      = load && cnt_q != 2'd0;
      ph_d     = load ? '0 : ph_q + 1'b1;
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      // head is slot 0, tail slot 1; a push lands in whichever slot is free after the pop
      head_d   = pop ? (cnt_q == 2'd2 ? tail_q : pcm_in) : (push && cnt_q == 2'd0 ? pcm_in : head_q);
      tail_d   = push && (cnt_q - {1'b0, pop}) == 2'd1 ? pcm_in : tail_q;
      x_d      = pop ? head_q : x_q;
      strobe_d = pop;
      under_d  = load && cnt_q == 2'd0;
      f        = pdm_q ? SW'(32768) : -SW'(32768);
      s1       = SW'(i1_q) + SW'(x_q >>> 1) - f;
      i1_d     = I1_W'(s1 > I1_MAX ? I1_MAX : s1 < I1_MIN ? I1_MIN : s1);
      s2       = SW'(i2_q) + SW'(i1_d) - f;
      i2_d     = I2_W'(s2 > I2_MAX ? I2_MAX : s2 < I2_MIN ? I2_MIN : s2);
      pdm_d    = ~i2_d[I2_W-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ph_q     <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
         tail_q   <= '0;
         x_q      <= '0;
         i1_q     <= '0;
         i2_q     <= '0;
         pdm_q    <= 1'b0;
         strobe_q <= 1'b0;
         under_q  <= 1'b0;
      end else begin
         ph_q     <= ph_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         x_q      <= x_d;
         i1_q     <= i1_d;
         i2_q     <= i2_d;
         pdm_q    <= pdm_d;
         strobe_q <= strobe_d;
         under_q  <= under_d;
      end
   end
endmodule

// File: tb/tb_pcm_to_pdm.sv
// tb_pcm_to_pdm: directed self-checking bench for pcm_to_pdm (OSR = 100).
module tb_pcm_to_pdm;
   logic clk = 1'b0, rst = 1'b1, pcm_valid = 1'b0;
   logic signed [15:0] pcm_in = '0;
   logic pcm_ready, pdm_out, sample_strobe, underrun;
   int n_cmp = 0, n_bad = 0, cyc = 0;
   int ones, ev, und, k;

   always #5 clk = ~clk;

   pcm_to_pdm #(.OSR(100), .I1_W(20), .I2_W(24)) dut (
      .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_valid(pcm_valid),
      .pcm_ready(pcm_ready), .pdm_out(pdm_out), .sample_strobe(sample_strobe), .underrun(underrun)
   );

   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_rng(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic count_ones(input int n, output int o);
      o = 0;
      for (int i = 0; i < n; i++) begin
         tick;
         o += int'(pdm_out);
      end
   endtask

   task automatic wait_ph(input int m);
      while (cyc % 100 != m) tick;
   endtask

   // mode 0: no pushes, 1: push every 100 cycles, 2: offer continuously
   task automatic run(input int n, input int mode, input logic signed [15:0] v, input int skip,
                      output int o, output int e, output int u);
      o = 0; e = 0; u = 0;
      for (int i = 0; i < n; i++) begin
         pcm_in    = v;
         pcm_valid = mode == 2 || (mode == 1 && i % 100 == 0);
         tick;
         if (i >= skip) begin
            o += int'(pdm_out);
            e += int'(sample_strobe) + int'(underrun);
            u += int'(underrun);
         end
      end
      pcm_valid = 1'b0;
   endtask

   task automatic first_load_after_release(input string tag);
      ev = 0;
      for (int i = 0; i < 99; i++) begin
         tick;
         ev += int'(sample_strobe) + int'(underrun);
      end
      check({tag, " quiet before first load"}, ev, 0);
      tick;
      check({tag, " first underrun"}, int'(underrun), 1);
      check({tag, " no strobe on empty load"}, int'(sample_strobe), 0);
   endtask

   initial begin
      #2;
      check("reset pdm_out", int'(pdm_out), 0);
      check("reset pcm_ready", int'(pcm_ready), 1);
      check("reset strobe", int'(sample_strobe), 0);
      check("reset underrun", int'(underrun), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      cyc = 0;
      first_load_after_release("rel1");
      tick;
      check("underrun is one cycle", int'(underrun), 0);
      // backpressure: A, B accepted, C refused
      pcm_valid = 1'b1; pcm_in = 16'sd32767;
      tick;
      pcm_in = 16'sh8000;
      tick;
      check("ready low after 2nd push", int'(pcm_ready), 0);
      pcm_in = 16'sd32767;
      tick;
      check("ready stays low on 3rd offer", int'(pcm_ready), 0);
      pcm_valid = 1'b0;
      wait_ph(0);
      check("strobe on load A", int'(sample_strobe), 1);
      count_ones(100, ones);
      check_rng("density while x=A", ones, 61, 100);
      check("strobe on load B", int'(sample_strobe), 1);
      count_ones(100, ones);
      check_rng("density while x=B", ones, 0, 39);
      check("third sample was dropped", int'(underrun), 1);
      count_ones(100, ones);
      check_rng("density held after underrun", ones, 0, 39);
      check("underrun repeats each period", int'(underrun), 1);
      // push coincident with a load while full
      pcm_valid = 1'b1; pcm_in = 16'sd1000;
      tick;
      tick;
      pcm_valid = 1'b0;
      wait_ph(99);
      pcm_valid = 1'b1; pcm_in = 16'sd2000;
      #1 check("ready low in full load cycle", int'(pcm_ready), 0);
      tick;
      pcm_valid = 1'b0;
      check("strobe on full load", int'(sample_strobe), 1);
      check("push in full load cycle refused", int'(pcm_ready), 1);
      wait_ph(99);
      tick;
      wait_ph(99);
      pcm_valid = 1'b1; pcm_in = 16'sd16384;
      tick;
      pcm_valid = 1'b0;
      check("empty load ignores same-cycle push", int'(underrun), 1);
      check("no strobe on empty load", int'(sample_strobe), 0);
      tick;
      wait_ph(0);
      check("late push loads next period", int'(sample_strobe), 1);
      // asynchronous reset while full with pdm_out high
      pcm_valid = 1'b1; pcm_in = 16'sd16384;
      tick;
      tick;
      pcm_valid = 1'b0;
      check("full before reset", int'(pcm_ready), 0);
      k = 0;
      while (!pdm_out && k < 90) begin
         tick;
         k++;
      end
      check("pdm high before reset", int'(pdm_out), 1);
      #3 rst = 1'b1;
      #1;
      check("async reset pdm_out", int'(pdm_out), 0);
      check("async reset pcm_ready", int'(pcm_ready), 1);
      check("async reset strobe", int'(sample_strobe), 0);
      check("async reset underrun", int'(underrun), 0);
      pcm_valid = 1'b1; pcm_in = 16'sd32767;
      repeat (3) @(posedge clk);
      #1 pcm_valid = 1'b0;
      rst = 1'b0;
      cyc = 0;
      first_load_after_release("rel2");
      // DC tests, window = last 4000 bits
      run(5000, 1, 16'sd0, 1000, ones, ev, und);
      check_rng("dc0 ones", ones, 1996, 2004);
      check("dc0 one event per period", ev, 40);
      check("dc0 no underrun", und, 0);
      run(5000, 2, 16'sd16384, 1000, ones, ev, und);
      check_rng("dc+16384 ones", ones, 2495, 2505);
      check("dc+16384 no underrun", und, 0);
      run(5000, 2, -16'sd16384, 1000, ones, ev, und);
      check_rng("dc-16384 ones", ones, 1495, 1505);
      check("dc-16384 one event per period", ev, 40);
      run(5000, 2, 16'sd32767, 1000, ones, ev, und);
      check_rng("full-scale pos ones", ones, 2980, 4000);
      run(5000, 2, 16'sh8000, 1000, ones, ev, und);
      check_rng("full-scale neg ones", ones, 0, 1020);
      run(2000, 0, 16'sd0, 1000, ones, ev, und);
      check_rng("starved density held", ones, 0, 255);
      check("starved underrun each period", und, 10);
      check("starved one event per period", ev, 10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
